// File: rtl/cgra_stream_checker_if.sv
// Bus bundle between the stream checker and whoever hosts it (system bench,
// FPGA harness). Groups control, pad stream and result signals. clk/reset
// stay as plain ports on the checker.
//
// Handshake semantics: there is no valid/ready pair. start_in is a level
// that is acted on only while the checker sits in IDLE or DONE; it is
// ignored while busy_out = 1. The pad streams run at one word per clock
// with no back-pressure. pad_data_out is valid whenever busy_out = 1 and
// is zero otherwise. Result outputs are stable while done_out = 1.
interface cgra_stream_checker_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32
);
  logic             start_in;
  logic [1:0]       mode_in;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] pad_data_out;
  logic [WIDTH-1:0] pad_data_in;
  logic             busy_out;
  logic             done_out;
  logic             pass_out;
  logic [CNT_W-1:0] error_count_out;
  logic [CNT_W-1:0] cycle_count_out;
  logic [CNT_W-1:0] first_err_index_out;
  // FSM state for debug and checker binding (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
  logic [1:0]       state_dbg;

  // Host side: drives control and the fabric response, reads results.
  modport master (
    output start_in, mode_in, seed_in, pad_data_in,
    input  pad_data_out, busy_out, done_out, pass_out,
           error_count_out, cycle_count_out, first_err_index_out, state_dbg
  );

  // Checker side.
  modport slave (
    input  start_in, mode_in, seed_in, pad_data_in,
    output pad_data_out, busy_out, done_out, pass_out,
           error_count_out, cycle_count_out, first_err_index_out, state_dbg
  );
endinterface

// File: rtl/cgra_stream_checker.sv
// Stimulus generator and response checker for full-system CGRA runs.
// Drives NUM_WORDS words onto the pad input tracks (bit WIDTH-1 -> track T0,
// bit 0 -> track T(WIDTH-1)), delays each driven word by LATENCY cycles and
// compares the fabric response against (word << SHIFT) truncated to WIDTH.
// Reports error count, cycles used and the index of the first bad word.
module cgra_stream_checker #(
  parameter int               WIDTH     = 16,
  parameter int               LATENCY   = 0,
  parameter int               SHIFT     = 1,
  parameter int               NUM_WORDS = 100,
  parameter logic [WIDTH-1:0] POLY      = 'hB400,
  parameter int               CNT_W     = 32
) (
  input logic               clk_in,
  input logic               reset_in,
  cgra_stream_checker_if.slave bus
);

  // Phase counter must hold NUM_WORDS-1 (RUN) and LATENCY-1 (DRAIN, <= 63).
  localparam int PW = $clog2(NUM_WORDS + 65) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pad_q, pad_d;
  logic [1:0]       mode_q, mode_d;
  logic [PW-1:0]    ph_q, ph_d;
  logic             load;

  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] first_q, first_d;

  logic             busy;
  logic             run_v;
  logic [WIDTH-1:0] seed_fix;
  logic [WIDTH-1:0] tap_w;
  logic             tap_v;
  logic [WIDTH-1:0] exp_resp;
  logic             mismatch;

  // Next stimulus word for the selected mode; mode 3 behaves as constant.
  function automatic logic [WIDTH-1:0] next_word(input logic [1:0] m,
                                                 input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    case (m)
      2'd1:    r = w + WIDTH'(1);
      2'd2:    r = w[0] ? ((w >> 1) ^ POLY) : (w >> 1);
      default: r = w;
    endcase
    return r;
  endfunction

  // An all-zero LFSR state would lock up, so a zero seed starts at 1.
  assign seed_fix = (bus.mode_in == 2'd2 && bus.seed_in == '0) ?
                    WIDTH'(1) : bus.seed_in;

  assign busy  = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign run_v = (state_q == S_RUN);

  // FSM next state plus stimulus register and phase counter updates.
  always_comb begin
    state_d = state_q;
    pad_d   = pad_q;
    mode_d  = mode_q;
    ph_d    = ph_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start_in) begin
          state_d = S_RUN;
          load    = 1'b1;
          pad_d   = seed_fix;
          mode_d  = bus.mode_in;
          ph_d    = '0;
        end
      end
      S_RUN: begin
        if (ph_q == PW'(NUM_WORDS - 1)) begin
          ph_d = '0;
          if (LATENCY > 0) begin
            // Hold the last word on the pads while responses drain.
            state_d = S_DRAIN;
          end else begin
            state_d = S_DONE;
            pad_d   = '0;
          end
        end else begin
          ph_d  = ph_q + PW'(1);
          pad_d = next_word(mode_q, pad_q);
        end
      end
      S_DRAIN: begin
        if (ph_q == PW'(LATENCY - 1)) begin
          state_d = S_DONE;
          pad_d   = '0;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and stimulus registers.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      pad_q   <= '0;
      mode_q  <= '0;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      pad_q   <= pad_d;
      mode_q  <= mode_d;
      ph_q    <= ph_d;
    end
  end

  // Expected-word delay line: word driven in cycle k reaches the tap in
  // cycle k+LATENCY together with its valid bit.
  generate
    if (LATENCY == 0) begin : g_no_delay
      assign tap_w = pad_q;
      assign tap_v = run_v;
    end else begin : g_delay
      logic [WIDTH-1:0]   dl_w_q [LATENCY];
      logic [LATENCY-1:0] dl_v_q;

      // Shift driven words and RUN-valid flags one stage per cycle.
      always_ff @(posedge clk_in) begin
        if (reset_in) begin
          dl_v_q <= '0;
          for (int i = 0; i < LATENCY; i++) dl_w_q[i] <= '0;
        end else begin
          dl_v_q[0] <= run_v;
          dl_w_q[0] <= pad_q;
          for (int i = 1; i < LATENCY; i++) begin
            dl_v_q[i] <= dl_v_q[i-1];
            dl_w_q[i] <= dl_w_q[i-1];
          end
        end
      end

      assign tap_w = dl_w_q[LATENCY-1];
      assign tap_v = dl_v_q[LATENCY-1];
    end
  endgenerate

  assign exp_resp = tap_w << SHIFT;
  assign mismatch = tap_v && (bus.pad_data_in != exp_resp);

  // Statistics: cleared on an accepted start, updated from the compare.
  always_comb begin
    err_d   = err_q;
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    first_d = first_q;
    if (load) begin
      err_d   = '0;
      cyc_d   = '0;
      idx_d   = '0;
      first_d = '1;
    end else begin
      if (busy) cyc_d = cyc_q + CNT_W'(1);
      if (tap_v) begin
        idx_d = idx_q + CNT_W'(1);
        if (mismatch) begin
          if (err_q != '1)   err_d   = err_q + CNT_W'(1);
          if (first_q == '1) first_d = idx_q;
        end
      end
    end
  end

  // Statistics registers; compare results land here one edge after the compare.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      err_q   <= '0;
      cyc_q   <= '0;
      idx_q   <= '0;
      first_q <= '1;
    end else begin
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      first_q <= first_d;
    end
  end

  assign bus.pad_data_out        = pad_q;
  assign bus.busy_out            = busy;
  assign bus.done_out            = (state_q == S_DONE);
  assign bus.pass_out            = (state_q == S_DONE) && (err_q == '0);
  assign bus.error_count_out     = err_q;
  assign bus.cycle_count_out     = cyc_q;
  assign bus.first_err_index_out = first_q;
  assign bus.state_dbg           = state_q;

endmodule
